// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: opcodes, FSM states and command layout.
package alu_seq_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_OPC_W    = 3;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_NOP = 3'b111
  } opc_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_WB    = 2'b11
  } state_e;

  // Opcode in the MSBs, destination index in the LSBs.
  typedef struct packed {
    logic [DEF_OPC_W-1:0]  op;
    logic [DEF_ADDR_W-1:0] src_a;
    logic [DEF_ADDR_W-1:0] src_b;
    logic [DEF_ADDR_W-1:0] dst;
  } cmd_t;

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU command sequencer: two operand read ports, a peek port and
// one write port where the writeback beats a same-index host write.
module alu_seq_regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] i_rd_a_addr,
  output logic [DATA_W-1:0] o_rd_a_data,
  input  logic [ADDR_W-1:0] i_rd_b_addr,
  output logic [DATA_W-1:0] o_rd_b_data,
  input  logic [ADDR_W-1:0] i_peek_addr,
  output logic [DATA_W-1:0] o_peek_data,
  input  logic              i_wb_en,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  input  logic              i_host_en,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DATA_W-1:0] i_host_data
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  assign o_rd_a_data = r_regs[i_rd_a_addr];
  assign o_rd_b_data = r_regs[i_rd_b_addr];
  assign o_peek_data = r_regs[i_peek_addr];

  // Per-entry update: writeback first, host write only when the writeback targets elsewhere.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i_wb_en && (i_wb_addr == ADDR_W'(i))) begin
          r_regs[i] <= i_wb_data;
        end else if (i_host_en && (i_host_addr == ADDR_W'(i))) begin
          r_regs[i] <= i_host_data;
        end
      end
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between a command source and an external ALU, with a host-loadable
// register file. Optional flag outputs flag_z/flag_n are built when ALU_FLAGS_EN is defined.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 8,
  parameter int  OPC_W    = 3,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int CMD_W    = OPC_W + 3 * ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd,
  output logic              alu_valid,
  output logic [OPC_W-1:0]  alu_op_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              cmd_done
`ifdef ALU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  state_e            r_state;
  state_e            w_state_next;
  logic [CMD_W-1:0]  r_cmd;
  logic [DATA_W-1:0] r_result;
  logic              r_alu_valid;
  logic [OPC_W-1:0]  r_alu_op_code;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic              r_cmd_done;

  logic [OPC_W-1:0]  w_op;
  logic [ADDR_W-1:0] w_src_a;
  logic [ADDR_W-1:0] w_src_b;
  logic [ADDR_W-1:0] w_dst;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_accept;
  logic              w_in_nop;
  logic              w_cmd_nop;
  logic              w_wb_en;

  assign w_op      = r_cmd[CMD_W-1 -: OPC_W];
  assign w_src_a   = r_cmd[3*ADDR_W-1 -: ADDR_W];
  assign w_src_b   = r_cmd[2*ADDR_W-1 -: ADDR_W];
  assign w_dst     = r_cmd[ADDR_W-1:0];
  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_in_nop  = (cmd[CMD_W-1 -: OPC_W] > OPC_W'(OP_NOT));
  assign w_cmd_nop = (w_op > OPC_W'(OP_NOT));
  assign w_wb_en   = (r_state == ST_WB) && !w_cmd_nop;

  alu_seq_regfile #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_regfile (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_rd_a_addr (w_src_a),
    .o_rd_a_data (w_rd_a),
    .i_rd_b_addr (w_src_b),
    .o_rd_b_data (w_rd_b),
    .i_peek_addr (host_addr),
    .o_peek_data (host_rdata),
    .i_wb_en     (w_wb_en),
    .i_wb_addr   (w_dst),
    .i_wb_data   (r_result),
    .i_host_en   (host_wr_en),
    .i_host_addr (host_addr),
    .i_host_data (host_wdata)
  );

  // Next-state decode; NOPs skip the ALU entirely and retire through WB without a write.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_in_nop) begin
          w_state_next = ST_WB;
        end else if (w_accept) begin
          w_state_next = ST_ISSUE;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (alu_done) begin
          w_state_next = ST_WB;
        end else begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WB:   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Operands are captured leaving ISSUE so a host write that landed earlier is seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_result      <= '0;
      r_alu_valid   <= 1'b0;
      r_alu_op_code <= OPC_W'(OP_NOP);
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_cmd_done    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cmd_done <= (w_state_next == ST_WB);
      if (w_accept) begin
        r_cmd <= cmd;
      end
      if (r_state == ST_ISSUE) begin
        r_alu_valid   <= 1'b1;
        r_alu_op_code <= w_op;
        r_alu_a       <= w_rd_a;
        r_alu_b       <= (w_op == OPC_W'(OP_NOT)) ? '0 : w_rd_b;
      end else if ((r_state == ST_WAIT) && alu_done) begin
        r_alu_valid <= 1'b0;
        r_result    <= alu_result;
      end
    end
  end

  assign cmd_ready   = (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign cmd_done    = r_cmd_done;
  assign alu_valid   = r_alu_valid;
  assign alu_op_code = r_alu_op_code;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;

`ifdef ALU_FLAGS_EN
  logic r_flag_z;
  logic r_flag_n;

  // Flags follow the written-back result and hold across NOPs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_flag_z <= 1'b0;
      r_flag_n <= 1'b0;
    end else if (w_wb_en) begin
      r_flag_z <= (r_result == '0);
      r_flag_n <= r_result[DATA_W-1];
    end
  end

  assign flag_z = r_flag_z;
  assign flag_n = r_flag_n;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: directed scenarios followed by random commands,
// checked against a register-array reference model and a behavioural ALU.
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;
  import alu_seq_pkg::*;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } issue_t;

  typedef struct {
    int   done_cyc;
    logic fz;
    logic fn;
  } retire_t;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd;
  logic        alu_valid;
  logic [2:0]  alu_op_code;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_done;
  logic [31:0] alu_result;
  logic        host_wr_en;
  logic [2:0]  host_addr;
  logic [31:0] host_wdata;
  logic [31:0] host_rdata;
  logic        busy;
  logic        cmd_done;
`ifdef ALU_FLAGS_EN
  logic        flag_z;
  logic        flag_n;
`endif

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          alu_delay;
  logic [31:0] ref_regs [8];
  logic        ref_fz;
  logic        ref_fn;
  issue_t      q_issue [$];
  retire_t     q_retire [$];

  alu_cmd_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd         (cmd),
    .alu_valid   (alu_valid),
    .alu_op_code (alu_op_code),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_done    (alu_done),
    .alu_result  (alu_result),
    .host_wr_en  (host_wr_en),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .busy        (busy),
    .cmd_done    (cmd_done)
`ifdef ALU_FLAGS_EN
    ,
    .flag_z      (flag_z),
    .flag_n      (flag_n)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Behavioural ALU: answers alu_delay cycles after it first sees alu_valid.
  initial begin : alu_model
    int d;
    alu_done   = 1'b0;
    alu_result = 32'd0;
    forever begin
      @(negedge clk);
      if (alu_valid) begin
        d = alu_delay;
        repeat (d) @(negedge clk);
        alu_result = alu_fn(alu_op_code, alu_a, alu_b);
        alu_done   = 1'b1;
        @(negedge clk);
        alu_done   = 1'b0;
      end
    end
  end

  // Issue monitor: operands on alu_valid rise, then held stable while it stays high.
  initial begin : issue_mon
    logic   prev;
    logic   have;
    issue_t cur;
    prev = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        have = 1'b0;
      end else begin
        if (alu_valid && !prev) begin
          if (q_issue.size() == 0) begin
            fail_now("unexpected_issue", "alu_valid rose with no command expected");
            have = 1'b0;
          end else begin
            cur  = q_issue.pop_front();
            have = 1'b1;
            check("issue_op", {29'd0, alu_op_code}, {29'd0, cur.op});
            check("issue_a", alu_a, cur.a);
            check("issue_b", alu_b, cur.b);
          end
        end else if (alu_valid && have) begin
          check("hold_op", {29'd0, alu_op_code}, {29'd0, cur.op});
          check("hold_a", alu_a, cur.a);
          check("hold_b", alu_b, cur.b);
        end
        if (alu_valid) begin
          check("ready_low_in_flight", {31'd0, cmd_ready}, 32'd0);
        end
        prev = alu_valid;
      end
    end
  end

  // Retire monitor: cmd_done timing and, when built, the flags that follow it.
  initial begin : retire_mon
    retire_t rt;
    forever begin
      @(negedge clk);
      if (reset_n && cmd_done) begin
        if (q_retire.size() == 0) begin
          fail_now("unexpected_done", "cmd_done pulsed with no command expected");
        end else begin
          rt = q_retire.pop_front();
          check("done_cycle", cyc, rt.done_cyc);
          check("busy_at_done", {31'd0, busy}, 32'd1);
`ifdef ALU_FLAGS_EN
          @(negedge clk);
          check("flag_z", {31'd0, flag_z}, {31'd0, rt.fz});
          check("flag_n", {31'd0, flag_n}, {31'd0, rt.fn});
`endif
        end
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      fail_now("idle_timeout", "cmd_ready still 0 after 200 cycles, expected 1");
    end
  endtask

  task automatic host_write(input int addr, input logic [31:0] data);
    wait_idle();
    host_wr_en = 1'b1;
    host_addr  = 3'(addr);
    host_wdata = data;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    ref_regs[addr] = data;
  endtask

  task automatic send(input logic [2:0] op, input int sa, input int sb, input int dst, input int d);
    cmd_t        c;
    issue_t      it;
    retire_t     rt;
    logic [31:0] r;
    wait_idle();
    alu_delay = d;
    c.op      = op;
    c.src_a   = 3'(sa);
    c.src_b   = 3'(sb);
    c.dst     = 3'(dst);
    cmd       = c;
    cmd_valid = 1'b1;
    if (op > 3'd4) begin
      rt.done_cyc = cyc + 1;
    end else begin
      rt.done_cyc = cyc + 3 + d;
      it.op = op;
      it.a  = ref_regs[sa];
      it.b  = (op == 3'd4) ? 32'd0 : ref_regs[sb];
      q_issue.push_back(it);
      r = alu_fn(op, it.a, it.b);
      ref_regs[dst] = r;
      ref_fz = (r == 32'd0);
      ref_fn = r[31];
    end
    rt.fz = ref_fz;
    rt.fn = ref_fn;
    q_retire.push_back(rt);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic sweep();
    wait_idle();
    for (int a = 0; a < 8; a++) begin
      host_addr = 3'(a);
      #1;
      check($sformatf("peek_r%0d", a), host_rdata, ref_regs[a]);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
    check("rst_alu_op", {29'd0, alu_op_code}, 32'd7);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_done", {31'd0, cmd_done}, 32'd0);
`ifdef ALU_FLAGS_EN
    check("rst_flag_z", {31'd0, flag_z}, 32'd0);
    check("rst_flag_n", {31'd0, flag_n}, 32'd0);
`endif
  endtask

  task automatic host_write_in_wb(input int addr, input logic [31:0] data);
    // Called right after send() with zero ALU delay returns: two more edges reach WB.
    @(posedge clk); #1;
    @(posedge clk); #1;
    host_wr_en = 1'b1;
    host_addr  = 3'(addr);
    host_wdata = data;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
  endtask

  initial begin : driver
    int op;
    n_checks   = 0;
    n_fail     = 0;
    cyc        = 0;
    alu_delay  = 0;
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd        = 12'd0;
    host_wr_en = 1'b0;
    host_addr  = 3'd0;
    host_wdata = 32'd0;
    ref_fz     = 1'b0;
    ref_fn     = 1'b0;
    for (int i = 0; i < 8; i++) ref_regs[i] = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset_n = 1'b1;
    sweep();

    // Basic ADD with a one-cycle ALU.
    host_write(1, 32'd5);
    host_write(2, 32'd3);
    send(3'd0, 1, 2, 3, 0);
    sweep();

    // Slow SUB: operands must hold for the whole wait.
    send(3'd1, 3, 1, 6, 4);
    sweep();

    // NOT ignores operand B.
    host_write(1, 32'h0000_00FF);
    send(3'd4, 1, 2, 5, 1);
    sweep();

    // NOPs retire without touching the ALU or registers.
    send(3'd7, 1, 2, 3, 0);
    send(3'd5, 2, 1, 1, 0);
    send(3'd6, 0, 0, 0, 0);
    sweep();

    // Host write colliding with writeback: same index loses, different index lands.
    host_write(1, 32'd4);
    host_write(2, 32'd3);
    send(3'd0, 1, 2, 4, 0);
    host_write_in_wb(4, 32'd9);
    sweep();
    send(3'd2, 5, 5, 4, 0);
    host_write_in_wb(5, 32'd9);
    ref_regs[5] = 32'd9;
    sweep();

    // Random commands with random ALU latency and occasional host loads.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        host_write($urandom_range(0, 7), $urandom);
      end
      op = $urandom_range(0, 7);
      send(3'(op), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 4));
    end
    sweep();

    // Reset while waiting on a slow ALU: outputs clear at once, regs wiped.
    send(3'd0, 1, 2, 6, 20);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    q_retire.delete();
    for (int i = 0; i < 8; i++) ref_regs[i] = 32'd0;
    ref_fz = 1'b0;
    ref_fn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("ready_after_reset", {31'd0, cmd_ready}, 32'd1);
    sweep();

    // Zero result after reset drives the zero flag when built.
    send(3'd0, 0, 0, 1, 0);
    host_write(2, 32'h8000_0000);
    send(3'd3, 2, 0, 3, 2);
    sweep();

    repeat (10) @(posedge clk);
    #1;
    check("issue_queue_drained", q_issue.size(), 32'd0);
    check("retire_queue_drained", q_retire.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
